// File: rtl/reset_sequencer.sv
// Reset sequencer: async-assert / sync-deassert, minimum assertion stretch, then ordered
// release of NUM_OUT reset domains. Define RESET_SEQ_ACK_EN for per-domain ack handshake + timeout.
module reset_sequencer #(
  parameter int NUM_OUT     = 4,
  parameter int SYNC_STAGES = 3,
  parameter int MIN_ASSERT  = 16,
  parameter int RELEASE_GAP = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               async_reset_n,
  input  logic               soft_reset,
`ifdef RESET_SEQ_ACK_EN
  input  logic [NUM_OUT-1:0] rst_ack,
  output logic               timeout_err,
`endif
  output logic [NUM_OUT-1:0] rst_out,
  output logic               done
);

  localparam int MAX_AG = (RELEASE_GAP > ACK_TIMEOUT) ? RELEASE_GAP : ACK_TIMEOUT;
  localparam int MAXV   = (MIN_ASSERT > MAX_AG) ? MIN_ASSERT : MAX_AG;
  localparam int CNT_W  = $clog2(MAXV + 1);
  localparam int IDX_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CNT_W-1:0] MA_LAST = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] RG_LAST = CNT_W'(RELEASE_GAP - 1);

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef RESET_SEQ_ACK_EN
  localparam logic [1:0] S_WACK = 2'd3;
  localparam logic [CNT_W-1:0] AT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] AT_FULL = CNT_W'(ACK_TIMEOUT);
`endif

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_ok;
  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;

  assign sync_ok = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      sync    <= '0;
      state   <= S_HOLD;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      done    <= 1'b0;
`ifdef RESET_SEQ_ACK_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], 1'b1};
      // Soft reset outranks any release scheduled for this edge.
      if (soft_reset) begin
        state   <= S_HOLD;
        cnt     <= '0;
        idx     <= '0;
        rst_out <= '1;
        done    <= 1'b0;
      end else begin
        case (state)
          S_HOLD: begin
            if (!sync_ok) begin
              cnt <= '0;
            end else if (cnt == MA_LAST) begin
              rst_out[0] <= 1'b0;
              idx        <= '0;
              cnt        <= '0;
`ifdef RESET_SEQ_ACK_EN
              state <= S_WACK;
`else
              if (NUM_OUT == 1) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_GAP;
              end
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_GAP: begin
            if (cnt == RG_LAST) begin
              cnt <= '0;
              idx <= idx + 1'b1;
              for (int k = 0; k < NUM_OUT; k++)
                if (k == int'(idx) + 1) rst_out[k] <= 1'b0;
`ifdef RESET_SEQ_ACK_EN
              state <= S_WACK;
`else
              if (int'(idx) == NUM_OUT - 2) begin
                state <= S_DONE;
                done  <= 1'b1;
              end
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef RESET_SEQ_ACK_EN
          S_WACK: begin
            if (rst_ack[idx]) begin
              cnt <= '0;
              if (int'(idx) == NUM_OUT - 1) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_GAP;
              end
            end else if (cnt == AT_FULL) begin
              // Flag was raised last edge; now restart the whole sequence.
              state   <= S_HOLD;
              cnt     <= '0;
              idx     <= '0;
              rst_out <= '1;
            end else begin
              cnt <= cnt + 1'b1;
              if (cnt == AT_LAST) timeout_err <= 1'b1;
            end
          end
`endif
          S_DONE: begin
          end
          default: begin
            state <= S_HOLD;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer; expectations are queued with the edge they are due on
// and checked as the clock reaches that edge. Ack scenarios run when RESET_SEQ_ACK_EN is set.
module tb_reset_sequencer;
  localparam int N  = 4;
  localparam int MA = 16;
  localparam int RG = 8;
  localparam int AT = 32;
`ifdef RESET_SEQ_ACK_EN
  localparam int AX = 1;
`else
  localparam int AX = 0;
`endif
  localparam int STEP = RG + AX;

  logic         clk = 1'b0;
  logic         async_reset_n = 1'b0;
  logic         soft_reset = 1'b0;
  logic [N-1:0] rst_out;
  logic         done;
`ifdef RESET_SEQ_ACK_EN
  logic [N-1:0] rst_ack;
  logic [N-1:0] ack_hold = '0;
  logic         timeout_err;
  // Domains acknowledge as soon as they are released unless held off.
  assign rst_ack = ~rst_out & ~ack_hold;
`endif

  reset_sequencer #(
    .NUM_OUT(N), .SYNC_STAGES(3), .MIN_ASSERT(MA), .RELEASE_GAP(RG), .ACK_TIMEOUT(AT)
  ) dut (
    .clk(clk),
    .async_reset_n(async_reset_n),
    .soft_reset(soft_reset),
`ifdef RESET_SEQ_ACK_EN
    .rst_ack(rst_ack),
    .timeout_err(timeout_err),
`endif
    .rst_out(rst_out),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    string        tag;
    int           sig;
    logic [N-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   ecount  = 0;
  int   vectors = 0;
  int   errors  = 0;

  function automatic logic [N-1:0] observe(int sig);
    case (sig)
      0: return rst_out;
      1: return N'(done);
`ifdef RESET_SEQ_ACK_EN
      2: return N'(timeout_err);
`endif
      default: return 'x;
    endcase
  endfunction

  task automatic check(string tag, logic [N-1:0] obs, logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_at(int cyc, string tag, int sig, logic [N-1:0] val);
    sb.push_back('{cyc, tag, sig, val});
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    ecount++;
    while (sb.size() > 0 && sb[0].cyc <= ecount) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sig), e.val);
    end
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  initial begin
    int b, s, r, last;

    // Power-on: held in reset
    #12;
    check("por_rst", rst_out, 4'hF);
    check("por_done", N'(done), '0);

    // Test 1: release between edges, full sequence
    tick();
    #4 async_reset_n = 1'b1;
    b = ecount;
    last = b + 19 + 3 * STEP;
    expect_at(b + 18, "t1_hold", 0, 4'hF);
    expect_at(b + 19, "t1_r0", 0, 4'hE);
    expect_at(b + 18 + STEP, "t1_r1_pre", 0, 4'hE);
    expect_at(b + 19 + STEP, "t1_r1", 0, 4'hC);
    expect_at(b + 19 + 2 * STEP, "t1_r2", 0, 4'h8);
    expect_at(last - 1, "t1_done_pre", 1, '0);
    expect_at(last, "t1_r3", 0, 4'h0);
    expect_at(last + AX, "t1_done", 1, 4'h1);
    ticks(last + AX + 1 - b);

    // Test 2: async glitch mid-sequence clears outputs without a clock edge
    #1 async_reset_n = 1'b0;
    #2 check("t2a_rst", rst_out, 4'hF);
    check("t2a_done", N'(done), '0);
    #1 async_reset_n = 1'b1;
    b = ecount;
    expect_at(b + 30, "t2_mid", 0, 4'hC);
    ticks(30);
    #1 async_reset_n = 1'b0;
    #2 check("t2b_rst", rst_out, 4'hF);
    check("t2b_done", N'(done), '0);
    #1 async_reset_n = 1'b1;
    b = ecount;
    last = b + 19 + 3 * STEP;
    expect_at(b + 18, "t2_hold", 0, 4'hF);
    expect_at(b + 19, "t2_r0", 0, 4'hE);
    expect_at(last, "t2_r3", 0, 4'h0);
    expect_at(last + AX, "t2_done", 1, 4'h1);
    ticks(last + AX + 1 - b);

    // Test 3: one-cycle soft reset from DONE
    b = ecount;
    expect_at(b + 1, "t3_soft_rst", 0, 4'hF);
    expect_at(b + 1, "t3_soft_done", 1, '0);
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    s = ecount;
    last = s + MA + 3 * STEP + AX;
    expect_at(s + MA - 1, "t3_hold", 0, 4'hF);
    expect_at(s + MA, "t3_r0", 0, 4'hE);
    expect_at(last - 1, "t3_done_pre", 1, '0);
    expect_at(last, "t3_done", 1, 4'h1);
    expect_at(last, "t3_rst_clr", 0, 4'h0);
    ticks(last + 1 - s);

    // Test 4: soft reset lands on the rst_out[2] release edge
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    s = ecount;
    r = s + MA + 2 * STEP;
    expect_at(r - 1, "t4_pre", 0, 4'hC);
    ticks(r - 1 - s);
    soft_reset = 1'b1;
    expect_at(r, "t4_clash_rst", 0, 4'hF);
    expect_at(r, "t4_clash_done", 1, '0);
    expect_at(r + 2, "t4_held", 0, 4'hF);
    ticks(3);
    soft_reset = 1'b0;
    s = ecount;
    expect_at(s + MA - 1, "t4_rehold", 0, 4'hF);
    expect_at(s + MA, "t4_r0", 0, 4'hE);
    ticks(MA);

`ifdef RESET_SEQ_ACK_EN
    // Test 5: rst_ack[1] arrives 5 cycles late
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    s = ecount;
    ack_hold = 4'b0010;
    r = s + MA + STEP;
    expect_at(r, "t5_r1", 0, 4'hC);
    expect_at(r + 13, "t5_r2_pre", 0, 4'hC);
    expect_at(r + 14, "t5_r2", 0, 4'h8);
    expect_at(r + 14, "t5_err", 2, '0);
    expect_at(r + 24, "t5_done", 1, 4'h1);
    ticks(r + 5 - s);
    ack_hold = '0;
    ticks(19);

    // Test 6: rst_ack[2] stuck low -> timeout, reassert, retry
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    s = ecount;
    ack_hold = 4'b0100;
    r = s + MA + 2 * STEP;
    expect_at(r, "t6_r2", 0, 4'h8);
    expect_at(r + AT - 1, "t6_err_pre", 2, '0);
    expect_at(r + AT, "t6_err", 2, 4'h1);
    expect_at(r + AT, "t6_still", 0, 4'h8);
    expect_at(r + AT + 1, "t6_reassert", 0, 4'hF);
    expect_at(r + AT + MA, "t6_retry_hold", 0, 4'hF);
    expect_at(r + AT + 1 + MA, "t6_retry_r0", 0, 4'hE);
    expect_at(r + AT + 1 + MA, "t6_sticky", 2, 4'h1);
    ticks(r + AT + 1 + MA - s);
    ack_hold = '0;
`endif

    check("sb_drain", N'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
